modmul_barrett_pipe: RTL and testbench
======================================

Name: modmul_barrett_pipe

Overview:
Pipelined, parametrised modular multiplier / multiply-add for NTT-style datapaths. It computes (a*b) mod Q or (a*b + c) mod Q for any odd modulus Q < 2^W, using Barrett reduction with a precomputed constant. It replaces the fixed-modulus, purely combinational multiplier with a 4-stage pipeline that has valid/ready flow control and a pass-through tag. It sits between the coefficient memories and the butterfly units.

Parameters:
W, 14, operand and result width in bits; Q < 2^W.
Q, 12289, modulus; must be odd and satisfy 2^(W-1) < Q < 2^W.
MU, 21843, Barrett constant, equal to floor(2^(2W)/Q); supplied by the instantiator and not computed in RTL.
TW, 4, width of the tag field.

Ports:
clk  in  1  clock; all logic is rising-edge triggered.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  input beat is valid.
in_ready  out  1  block can accept an input beat.
op  in  1  0 = a*b mod Q; 1 = (a*b + c) mod Q.
a  in  W  operand a; must be < Q.
b  in  W  operand b; must be < Q.
c  in  W  addend; used only when op=1; must be < Q.
tag  in  TW  user tag, passed through unchanged.
out_valid  out  1  result beat is valid.
out_ready  in  1  downstream accepts the result beat.
p  out  W  result; always < Q when range_err=0.
out_tag  out  TW  tag captured with the matching input.
range_err  out  1  set on a result beat whose a, b, or c (c only when op=1) was >= Q.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, p=0, out_tag=0, range_err=0, and every internal stage-valid bit cleared. in_ready=1 in the first cycle after reset. Any in-flight beats are discarded, with no partial output.
- Advance condition: adv = !out_valid | out_ready. in_ready = adv, driven combinationally.
- Stall: the whole pipeline stalls as one unit; there is no bubble collapsing. Beats are accepted on in_valid & in_ready. While adv=0, every stage register, p, out_tag, and range_err hold their values.
- Pipeline stages, each registered on adv:
  - S1: x = a*b + (op ? c : 0), width 2W+1. Capture tag and the range-check flag.
  - S2: q = ((x >> (W-1)) * MU) >> (W+1).
  - S3: r = x - q*Q, computed modulo 2^(W+2). Barrett guarantees 0 <= r < 3Q for in-range inputs.
  - S4: r1 = r >= Q ? r - Q : r; then p = r1 >= Q ? r1 - Q : r1. Output registered with out_valid=1.
- Latency: exactly 4 clk cycles from the accepting edge to out_valid, when out_ready is held high. Throughput is 1 beat per cycle.
- Stage-valid bits: they propagate with the data. Invalid slots (bubbles) travel through the pipeline but never raise out_valid.
- Out-of-range inputs: range_err=1 on that beat. p is the low W bits of the two-correction result; its value is not otherwise constrained, and no assertion is raised in RTL.
- A beat presented with in_valid=1 while in_ready=0 is not consumed. The upstream source must hold its data.
- Ordering: results are in strict input order, with no reordering and no drops.
- Simultaneous accept and output: handled normally; the pipeline shifts by one slot.
- Width rules: all arithmetic is unsigned. Intermediate widths are sized so that no intermediate overflow occurs for Q < 2^W.

Test Plan:
1. Reset, then a=5000, b=7000, op=0, tag=3, out_ready=1 -> after 4 cycles: out_valid=1, p=928, out_tag=3, range_err=0.
2. a=12288, b=12288, op=0 -> p=1. Then a=0, b=9999 -> p=0, arriving on the next cycle (back-to-back throughput).
3. op=1, a=12288, b=1, c=1 -> p=0. op=1, a=2, b=3, c=12288 -> p=5.
4. Stream of 8 beats with tags 0..7 and out_ready=0 for cycles 5-7 -> in_ready=0 during the stall, outputs held stable, all 8 results in order with correct values, no loss or duplication.
5. rst_n=0 for one cycle while 3 beats are in flight -> out_valid=0, p=0 the next cycle; no stale results appear afterwards.
6. a=12289, b=2, op=0 -> range_err=1 on that beat. Random in-range regression (10k beats, random out_ready) checked against a reference model of (a*b+c) % 12289.

Source files
------------

// File: rtl/modmul_barrett_pipe.sv
// rtl/modmul_barrett_pipe.sv - 4-stage Barrett modular multiply / multiply-add with valid/ready and tag
module modmul_barrett_pipe #(
  parameter int W  = 14,
  parameter int Q  = 12289,
  parameter int MU = 21843,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [TW-1:0] tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  p,
  output logic [TW-1:0] out_tag,
  output logic          range_err
);

  // x = a*b + c needs 2W+1 bits; the Barrett remainder stays below 3Q < 2^(W+2)
  localparam int XW = 2 * W + 1;
  localparam int RW = W + 2;
  localparam int MW = (W + 2) + (W + 1);

  localparam logic [W-1:0]  Q_W  = W'(Q);
  localparam logic [RW-1:0] Q_R  = RW'(Q);
  localparam logic [MW-1:0] MU_M = MW'(MU);

  // The whole pipe moves as one unit whenever the output slot is free or being taken
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 inputs: product plus optional addend, and the operand range flag
  logic [W-1:0]  addend;
  logic [XW-1:0] x_next;
  logic          err_next;
  assign addend   = op ? c : '0;
  assign x_next   = XW'(a) * XW'(b) + XW'(addend);
  assign err_next = (a >= Q_W) || (b >= Q_W) || (op && (c >= Q_W));

  logic          s1_valid;
  logic [XW-1:0] s1_x;
  logic [TW-1:0] s1_tag;
  logic          s1_err;

  // Stage 2 quotient estimate: only the top W+2 bits of x feed the MU multiply
  logic [MW-1:0] q_prod;
  logic [RW-1:0] q_next;
  assign q_prod = MW'(s1_x[XW-1:W-1]) * MU_M;
  assign q_next = q_prod[MW-1:W+1];

  logic          s2_valid;
  logic [RW-1:0] s2_x;
  logic [RW-1:0] s2_q;
  logic [TW-1:0] s2_tag;
  logic          s2_err;

  // Stage 3 remainder: exact modulo 2^(W+2) because the true value is below 3Q
  logic [RW-1:0] qq;
  logic [RW-1:0] r_next;
  assign qq     = s2_q * Q_R;
  assign r_next = s2_x - qq;

  logic          s3_valid;
  logic [RW-1:0] s3_r;
  logic [TW-1:0] s3_tag;
  logic          s3_err;

  // Stage 4: two conditional subtractions bring r from [0,3Q) into [0,Q)
  logic [RW-1:0] r1;
  logic [RW-1:0] r2;
  assign r1 = (s3_r >= Q_R) ? s3_r - Q_R : s3_r;
  assign r2 = (r1 >= Q_R) ? r1 - Q_R : r1;

  logic unused_bits;
  assign unused_bits = ^{q_prod[W:0], r2[RW-1:W]};

  // Stage 1 register: capture operands' combined value, tag and range flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_tag   <= '0;
      s1_err   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_x     <= x_next;
      s1_tag   <= tag;
      s1_err   <= err_next;
    end
  end

  // Stage 2 register: quotient estimate alongside the low bits of x
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_q     <= '0;
      s2_tag   <= '0;
      s2_err   <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_x     <= s1_x[RW-1:0];
      s2_q     <= q_next;
      s2_tag   <= s1_tag;
      s2_err   <= s1_err;
    end
  end

  // Stage 3 register: unreduced remainder
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_r     <= '0;
      s3_tag   <= '0;
      s3_err   <= 1'b0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_r     <= r_next;
      s3_tag   <= s2_tag;
      s3_err   <= s2_err;
    end
  end

  // Output register: final reduced result held until downstream takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      out_tag   <= '0;
      range_err <= 1'b0;
    end else if (adv) begin
      out_valid <= s3_valid;
      p         <= r2[W-1:0];
      out_tag   <= s3_tag;
      range_err <= s3_err;
    end
  end

endmodule

// File: tb/tb_modmul_barrett_pipe.sv
// tb/tb_modmul_barrett_pipe.sv - scoreboard bench for modmul_barrett_pipe
module tb_modmul_barrett_pipe;

  localparam int W  = 14;
  localparam int Q  = 12289;
  localparam int MU = 21843;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic [TW-1:0] tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  p;
  logic [TW-1:0] out_tag;
  logic          range_err;

  modmul_barrett_pipe #(.W(W), .Q(Q), .MU(MU), .TW(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .tag       (tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .out_tag   (out_tag),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  p;
    logic [TW-1:0] tag;
    logic          err;
    logic          skip_p;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   check_lat = 1'b0;
  bit   rand_mode = 1'b0;

  logic          prev_hold = 1'b0;
  logic          prev_valid;
  logic [W-1:0]  prev_p;
  logic [TW-1:0] prev_tag;
  logic          prev_err;

  task automatic chk(input string name, input longint got, input longint expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic o, input int av, input int bv, input int cv,
                                 input logic [TW-1:0] t);
    exp_t   e;
    longint x;
    x        = longint'(av) * longint'(bv) + (o ? longint'(cv) : 64'd0);
    e.p      = W'(x % Q);
    e.err    = (av >= Q) || (bv >= Q) || (o && (cv >= Q));
    e.skip_p = e.err;
    e.tag    = t;
    e.cyc    = cyc;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: transfers are decided at the negedge before the edge that performs them
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, prev_valid);
        chk("hold_p", p, prev_p);
        chk("hold_tag", out_tag, prev_tag);
        chk("hold_err", range_err, prev_err);
      end
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          if (!e.skip_p) chk("p", p, e.p);
          chk("out_tag", out_tag, e.tag);
          chk("range_err", range_err, e.err);
          if (check_lat) chk("latency", cyc - e.cyc, 4);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(op, int'(a), int'(b), int'(c), tag));
    end
    prev_hold  = rst_n && out_valid && !out_ready;
    prev_valid = out_valid;
    prev_p     = p;
    prev_tag   = out_tag;
    prev_err   = range_err;
  end

  task automatic send(input logic o, input int av, input int bv, input int cv, input int t);
    int n = 0;
    in_valid = 1'b1;
    op       = o;
    a        = W'(av);
    b        = W'(bv);
    c        = W'(cv);
    tag      = TW'(t);
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    c         = '0;
    tag       = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed values with fixed latency
    check_lat = 1'b1;
    send(1'b0, 5000, 7000, 0, 3);
    drain();
    send(1'b0, 12288, 12288, 0, 1);
    send(1'b0, 0, 9999, 0, 2);
    send(1'b1, 12288, 1, 1, 4);
    send(1'b1, 2, 3, 12288, 5);
    send(1'b0, 1, 1, 16383, 6);
    send(1'b0, 12289, 2, 0, 7);
    send(1'b1, 1, 1, 12289, 8);
    send(1'b0, 12288, 16383, 0, 9);
    drain();

    // Stream of 8 with a downstream stall in the middle
    check_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(1'b0, int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)), 0, i);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight; nothing stale may emerge afterwards
    check_lat = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b1, 100 + i, 200, 300, 10 + i);
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    send(1'b0, 3, 4, 0, 15);
    drain();

    // Random regression with random downstream back-pressure
    check_lat = 1'b0;
    rand_mode = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(1'($urandom_range(0, 1)), int'($urandom_range(0, Q - 1)),
               int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
               int'($urandom_range(0, 15)));
        end
        rand_mode = 1'b0;
      end
      begin
        while (rand_mode) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
